bank_group_ctrl: RTL and testbench

- Parametrised successor to the existing bank-group wrapper.
- Replaces the fixed BAWIDTH**2 bank fan-out with a BANKS-wide command router.
- Tracks per-bank state (IDLE/ACTIVATING/ACTIVE/PRECHARGING) and the open row of each bank.
- Enforces DDR4 intra-group timing (tRCD, tRAS, tRP, tCCD_L, tRRD_L) and flags illegal commands. Sits between the DDR command decoder and the Bank instances.

---
 rtl/bank_group_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_bank_group_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_group_ctrl.sv
// bank_group_ctrl -- command router and timing checker for one DDR4 bank group.
//
// Sits between the DDR command decoder and the Bank instances. Keeps a small
// FSM per bank (IDLE/ACTIVATING/ACTIVE/PRECHARGING), the open row of every bank,
// per-bank tRCD/tRAS/tRP timers and group tCCD_L/tRRD_L timers. Each valid
// command is either accepted (routed to its bank) or rejected.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   halt           freeze all state and timers; commands are ignored
//   cmd_valid      command present this cycle
//   cmd[2:0]       0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 reserved
//   ba, row        target bank, row address for ACT
//   cmd_ok/err     accept / reject pulse, one cycle after the command edge
//   bank_sel       one-hot target of an accepted ACT/RD/WR/PRE; all ones for PREA/REF
//   rd/wr_pulse    accepted RD / WR
//   act_row        ACT row on ACT, open row of the target bank on RD/WR
//   bank_state     2 bits per bank, bank i at [2i+1:2i]
module bank_group_ctrl #(
  parameter int BANKS     = 4,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int TRCD      = 4,
  parameter int TRAS      = 10,
  parameter int TRP       = 4,
  parameter int TCCD_L    = 2,
  parameter int TRRD_L    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   halt,
  input  logic                   cmd_valid,
  input  logic [2:0]             cmd,
  input  logic [BAWIDTH-1:0]     ba,
  input  logic [ADDRWIDTH-1:0]   row,
  output logic                   cmd_ok,
  output logic                   cmd_err,
  output logic [BANKS-1:0]       bank_sel,
  output logic                   rd_pulse,
  output logic                   wr_pulse,
  output logic [ADDRWIDTH-1:0]   act_row,
  output logic [2*BANKS-1:0]     bank_state
);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ACTIVATING  = 2'd1,
    ST_ACTIVE      = 2'd2,
    ST_PRECHARGING = 2'd3
  } bank_st_e;

  localparam logic [7:0]         RCD_LD  = 8'(TRCD - 1);
  localparam logic [7:0]         RAS_LD  = 8'(TRAS - 1);
  localparam logic [7:0]         RP_LD   = 8'(TRP - 1);
  localparam logic [7:0]         CCD_LD  = 8'(TCCD_L - 1);
  localparam logic [7:0]         RRD_LD  = 8'(TRRD_L - 1);
  localparam logic [BAWIDTH:0]   BANKS_W = (BAWIDTH + 1)'(BANKS);

  bank_st_e             state_q    [BANKS];
  logic [7:0]           rcd_q      [BANKS];
  logic [7:0]           ras_q      [BANKS];
  logic [7:0]           rp_q       [BANKS];
  logic [ADDRWIDTH-1:0] open_row_q [BANKS];
  logic [7:0]           ccd_q, rrd_q;

  logic                 cmd_ok_q, cmd_err_q, rd_pulse_q, wr_pulse_q;
  logic [BANKS-1:0]     bank_sel_q;
  logic [ADDRWIDTH-1:0] act_row_q;

  logic                 ok_d, err_d, rd_d, wr_d, ccd_ld, rrd_ld;
  logic [BANKS-1:0]     sel_d, act_en, pre_en, tgt;
  logic [ADDRWIDTH-1:0] row_d, tgt_row;
  logic                 ba_ok;

  // A timer that reached 0 on the previous edge already makes the command
  // legal, even though the FSM register only moves on this edge. These
  // "effective" views fold that one-cycle lag into the legality checks.
  logic [BANKS-1:0] eff_idle, eff_open, eff_active, pre_ready;

  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
    assign eff_idle[gi]   = (state_q[gi] == ST_IDLE) ||
                            (state_q[gi] == ST_PRECHARGING && rp_q[gi] == 8'd0);
    assign eff_open[gi]   = (state_q[gi] == ST_ACTIVATING) || (state_q[gi] == ST_ACTIVE);
    assign eff_active[gi] = (state_q[gi] == ST_ACTIVE) ||
                            (state_q[gi] == ST_ACTIVATING && rcd_q[gi] == 8'd0);
    assign pre_ready[gi]  = eff_open[gi] && (ras_q[gi] == 8'd0);
    assign bank_state[2*gi +: 2] = state_q[gi];
  end

  assign ba_ok = ({1'b0, ba} < BANKS_W);
  assign tgt   = ba_ok ? (BANKS'(1) << ba) : '0;

  always_comb begin
    tgt_row = '0;
    for (int i = 0; i < BANKS; i++) begin
      if (tgt[i]) tgt_row = open_row_q[i];
    end
  end

  // Command decode against pre-edge state.
  always_comb begin
    ok_d   = 1'b0;
    err_d  = 1'b0;
    rd_d   = 1'b0;
    wr_d   = 1'b0;
    sel_d  = '0;
    row_d  = '0;
    act_en = '0;
    pre_en = '0;
    ccd_ld = 1'b0;
    rrd_ld = 1'b0;
    if (!halt && cmd_valid) begin
      case (cmd)
        3'd0: ;
        3'd1: begin
          if (|(tgt & eff_idle) && rrd_q == 8'd0) begin
            ok_d = 1'b1; sel_d = tgt; act_en = tgt; row_d = row; rrd_ld = 1'b1;
          end else err_d = 1'b1;
        end
        3'd2, 3'd3: begin
          if (|(tgt & eff_active) && ccd_q == 8'd0) begin
            ok_d = 1'b1; sel_d = tgt; row_d = tgt_row; ccd_ld = 1'b1;
            rd_d = (cmd == 3'd2);
            wr_d = (cmd == 3'd3);
          end else err_d = 1'b1;
        end
        3'd4: begin
          if (|(tgt & pre_ready)) begin
            ok_d = 1'b1; sel_d = tgt; pre_en = tgt;
          end else if (|(tgt & eff_idle)) begin
            ok_d = 1'b1;  // PRE to a closed bank is harmless
          end else err_d = 1'b1;
        end
        3'd5: begin
          if (&(eff_idle | pre_ready)) begin
            ok_d = 1'b1; sel_d = '1; pre_en = pre_ready;
          end else err_d = 1'b1;
        end
        3'd6: begin
          if (&eff_idle) begin
            ok_d = 1'b1; sel_d = '1;
          end else err_d = 1'b1;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BANKS; i++) begin
        state_q[i]    <= ST_IDLE;
        rcd_q[i]      <= 8'd0;
        ras_q[i]      <= 8'd0;
        rp_q[i]       <= 8'd0;
        open_row_q[i] <= '0;
      end
      ccd_q      <= 8'd0;
      rrd_q      <= 8'd0;
      cmd_ok_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
      rd_pulse_q <= 1'b0;
      wr_pulse_q <= 1'b0;
      bank_sel_q <= '0;
      act_row_q  <= '0;
    end else begin
      // Decode is already gated by halt, so outputs fall to 0 while halted.
      cmd_ok_q   <= ok_d;
      cmd_err_q  <= err_d;
      rd_pulse_q <= rd_d;
      wr_pulse_q <= wr_d;
      bank_sel_q <= sel_d;
      act_row_q  <= row_d;
      if (!halt) begin
        ccd_q <= ccd_ld ? CCD_LD : ((ccd_q != 8'd0) ? ccd_q - 8'd1 : 8'd0);
        rrd_q <= rrd_ld ? RRD_LD : ((rrd_q != 8'd0) ? rrd_q - 8'd1 : 8'd0);
        for (int i = 0; i < BANKS; i++) begin
          if (rcd_q[i] != 8'd0) rcd_q[i] <= rcd_q[i] - 8'd1;
          if (ras_q[i] != 8'd0) ras_q[i] <= ras_q[i] - 8'd1;
          if (rp_q[i]  != 8'd0) rp_q[i]  <= rp_q[i]  - 8'd1;
          case (state_q[i])
            ST_ACTIVATING:  if (rcd_q[i] == 8'd0) state_q[i] <= ST_ACTIVE;
            ST_PRECHARGING: if (rp_q[i]  == 8'd0) state_q[i] <= ST_IDLE;
            default: ;
          endcase
          // Command-driven transitions override the timer-driven ones above.
          if (act_en[i]) begin
            state_q[i]    <= ST_ACTIVATING;
            rcd_q[i]      <= RCD_LD;
            ras_q[i]      <= RAS_LD;
            open_row_q[i] <= row;
          end
          if (pre_en[i]) begin
            state_q[i] <= ST_PRECHARGING;
            rp_q[i]    <= RP_LD;
          end
        end
      end
    end
  end

  assign cmd_ok   = cmd_ok_q;
  assign cmd_err  = cmd_err_q;
  assign rd_pulse = rd_pulse_q;
  assign wr_pulse = wr_pulse_q;
  assign bank_sel = bank_sel_q;
  assign act_row  = act_row_q;

endmodule

// File: tb/tb_bank_group_ctrl.sv
// Directed testbench for bank_group_ctrl with default parameters
// (4 banks, TRCD=4, TRAS=10, TRP=4, TCCD_L=2, TRRD_L=2).
// Observed outputs are packed as {cmd_ok, cmd_err, bank_sel[3:0], rd, wr, act_row[16:0]}.
module tb_bank_group_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        halt = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic [1:0]  ba = 2'd0;
  logic [16:0] row = 17'd0;
  logic        cmd_ok, cmd_err, rd_pulse, wr_pulse;
  logic [3:0]  bank_sel;
  logic [16:0] act_row;
  logic [7:0]  bank_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [24:0] exp_v;

  wire [24:0] obs = {cmd_ok, cmd_err, bank_sel, rd_pulse, wr_pulse, act_row};

  bank_group_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .halt       (halt),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .ba         (ba),
    .row        (row),
    .cmd_ok     (cmd_ok),
    .cmd_err    (cmd_err),
    .bank_sel   (bank_sel),
    .rd_pulse   (rd_pulse),
    .wr_pulse   (wr_pulse),
    .act_row    (act_row),
    .bank_state (bank_state)
  );

  always #5 clk = ~clk;

  // Present one command for exactly one edge; outputs are sampled 1 ns later.
  task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [16:0] r);
    cmd_valid = 1'b1; cmd = c; ba = b; row = r;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd = 3'd0; ba = 2'd0; row = 17'd0;
    $display("cmd=%0d ba=%0d row=%h -> ok=%b err=%b sel=%b rd=%b wr=%b act_row=%h state=%h",
             c, b, r, cmd_ok, cmd_err, bank_sel, rd_pulse, wr_pulse, act_row, bank_state);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs !== 25'd0 || bank_state !== 8'h00) begin
      $display("FAIL reset_state: got obs=%h state=%h expected obs=0 state=00", obs, bank_state);
      n_fail++;
    end
    for (int i = 0; i < 10; i++) begin
      idle(1);
      n_checks++;
      if (obs !== 25'd0 || bank_state !== 8'h00) begin
        $display("FAIL idle_quiet[%0d]: got obs=%h state=%h expected obs=0 state=00", i, obs, bank_state);
        n_fail++;
      end
    end
    issue(3'd7, 2'd0, 17'd0);
    exp_v = {1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 17'h0};
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL reserved_cmd: got %h expected %h", obs, exp_v); n_fail++;
    end
    // A NOP with valid raises neither flag.
    issue(3'd0, 2'd1, 17'd0);
    n_checks++;
    if (obs !== 25'd0) begin
      $display("FAIL nop_valid: got %h expected 0", obs); n_fail++;
    end
  endtask

  task automatic test_trcd();
    do_reset();
    issue(3'd1, 2'd2, 17'h1A2B);                               // t0
    exp_v = {1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 17'h1A2B};
    n_checks++;
    if (obs !== exp_v || bank_state !== 8'h10) begin
      $display("FAIL act_b2: got obs=%h state=%h expected obs=%h state=10", obs, bank_state, exp_v); n_fail++;
    end
    idle(2);
    issue(3'd2, 2'd2, 17'd0);                                  // t0+3
    exp_v = {1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 17'h0};
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL rd_early_trcd: got %h expected %h", obs, exp_v); n_fail++;
    end
    issue(3'd2, 2'd2, 17'd0);                                  // t0+4
    exp_v = {1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 17'h1A2B};
    n_checks++;
    if (obs !== exp_v || bank_state !== 8'h20) begin
      $display("FAIL rd_at_trcd: got obs=%h state=%h expected obs=%h state=20", obs, bank_state, exp_v); n_fail++;
    end
  endtask

  task automatic test_tras_trp();
    do_reset();
    issue(3'd1, 2'd0, 17'h00005);                              // t0
    idle(8);
    issue(3'd4, 2'd0, 17'd0);                                  // t0+9
    exp_v = {1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 17'h0};
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL pre_early_tras: got %h expected %h", obs, exp_v); n_fail++;
    end
    issue(3'd4, 2'd0, 17'd0);                                  // t0+10
    exp_v = {1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 17'h0};
    n_checks++;
    if (obs !== exp_v || bank_state !== 8'h03) begin
      $display("FAIL pre_at_tras: got obs=%h state=%h expected obs=%h state=03", obs, bank_state, exp_v); n_fail++;
    end
    idle(2);
    issue(3'd1, 2'd0, 17'h00006);                              // t0+13
    exp_v = {1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 17'h0};
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL act_early_trp: got %h expected %h", obs, exp_v); n_fail++;
    end
    issue(3'd1, 2'd0, 17'h00006);                              // t0+14
    exp_v = {1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 17'h00006};
    n_checks++;
    if (obs !== exp_v || bank_state !== 8'h01) begin
      $display("FAIL act_at_trp: got obs=%h state=%h expected obs=%h state=01", obs, bank_state, exp_v); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(3'd1, 2'd0, 17'h00111);                              // t0
    issue(3'd1, 2'd1, 17'h1FFFF);                              // t0+1
    exp_v = {1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 17'h0};
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL act_early_trrd: got %h expected %h", obs, exp_v); n_fail++;
    end
    issue(3'd1, 2'd1, 17'h1FFFF);                              // t0+2
    exp_v = {1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 17'h1FFFF};
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL act_at_trrd: got %h expected %h", obs, exp_v); n_fail++;
    end
    idle(3);
    issue(3'd3, 2'd1, 17'd0);                                  // t0+6
    exp_v = {1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 17'h1FFFF};
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL wr_b1: got %h expected %h", obs, exp_v); n_fail++;
    end
    issue(3'd3, 2'd0, 17'd0);                                  // t0+7
    exp_v = {1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 17'h0};
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL wr_early_tccd: got %h expected %h", obs, exp_v); n_fail++;
    end
    issue(3'd3, 2'd0, 17'd0);                                  // t0+8
    exp_v = {1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 17'h00111};
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL wr_at_tccd: got %h expected %h", obs, exp_v); n_fail++;
    end
  endtask

  task automatic test_ref_prea();
    do_reset();
    issue(3'd1, 2'd0, 17'h00020);                              // t0
    idle(1);
    issue(3'd1, 2'd3, 17'h00030);                              // t0+2
    issue(3'd6, 2'd0, 17'd0);                                  // t0+3
    exp_v = {1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 17'h0};
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL ref_banks_open: got %h expected %h", obs, exp_v); n_fail++;
    end
    idle(7);
    issue(3'd5, 2'd0, 17'd0);                                  // t0+11
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL prea_early_tras: got %h expected %h", obs, exp_v); n_fail++;
    end
    issue(3'd5, 2'd0, 17'd0);                                  // t0+12
    exp_v = {1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 17'h0};
    n_checks++;
    if (obs !== exp_v || bank_state !== 8'hC3) begin
      $display("FAIL prea_ok: got obs=%h state=%h expected obs=%h state=c3", obs, bank_state, exp_v); n_fail++;
    end
    idle(2);
    issue(3'd6, 2'd0, 17'd0);                                  // t0+15
    exp_v = {1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 17'h0};
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL ref_early_trp: got %h expected %h", obs, exp_v); n_fail++;
    end
    issue(3'd6, 2'd0, 17'd0);                                  // t0+16
    exp_v = {1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 17'h0};
    n_checks++;
    if (obs !== exp_v || bank_state !== 8'h00) begin
      $display("FAIL ref_ok: got obs=%h state=%h expected obs=%h state=00", obs, bank_state, exp_v); n_fail++;
    end
    issue(3'd4, 2'd1, 17'd0);
    exp_v = {1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 17'h0};
    n_checks++;
    if (obs !== exp_v || bank_state !== 8'h00) begin
      $display("FAIL pre_idle_bank: got obs=%h state=%h expected obs=%h state=00", obs, bank_state, exp_v); n_fail++;
    end
  endtask

  task automatic test_halt_reset();
    do_reset();
    issue(3'd1, 2'd1, 17'h00ABC);                              // t0
    halt = 1'b1; cmd_valid = 1'b1; cmd = 3'd2; ba = 2'd1;
    for (int i = 0; i < 5; i++) begin                          // t0+1 .. t0+5
      @(posedge clk); #1;
      n_checks++;
      if (obs !== 25'd0 || bank_state !== 8'h04) begin
        $display("FAIL halt_freeze[%0d]: got obs=%h state=%h expected obs=0 state=04", i, obs, bank_state);
        n_fail++;
      end
    end
    halt = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; ba = 2'd0;
    idle(2);
    issue(3'd2, 2'd1, 17'd0);                                  // t0+8
    exp_v = {1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 17'h0};
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL rd_early_after_halt: got %h expected %h", obs, exp_v); n_fail++;
    end
    issue(3'd2, 2'd1, 17'd0);                                  // t0+9
    exp_v = {1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 17'h00ABC};
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL rd_after_halt: got %h expected %h", obs, exp_v); n_fail++;
    end
    idle(5);
    issue(3'd4, 2'd1, 17'd0);                                  // t0+15
    exp_v = {1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 17'h0};
    n_checks++;
    if (obs !== exp_v || bank_state !== 8'h0C) begin
      $display("FAIL pre_after_halt: got obs=%h state=%h expected obs=%h state=0c", obs, bank_state, exp_v); n_fail++;
    end
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    n_checks++;
    if (obs !== 25'd0 || bank_state !== 8'h00) begin
      $display("FAIL reset_mid_pre: got obs=%h state=%h expected obs=0 state=00", obs, bank_state); n_fail++;
    end
    issue(3'd1, 2'd1, 17'h00042);
    exp_v = {1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 17'h00042};
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL act_after_reset: got %h expected %h", obs, exp_v); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_trcd();
    test_tras_trp();
    test_back_to_back();
    test_ref_prea();
    test_halt_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
